// File: rtl/img_pkg.sv
// img_pkg: shared types and constants for the image fetch slice.
//   state_t      scheduler states (S_WAIT_SOF, S_SCAN)
//   ADDR_W       ROM address width
//   H_W / V_W    scan column / row widths
//   H_ACTIVE / V_ACTIVE  visible raster size
//   IMG_W_DEF / IMG_H_DEF default image size, X0_DEF / Y0_DEF default placement
package img_pkg;

  localparam int ADDR_W    = 15;
  localparam int H_W       = 10;
  localparam int V_W       = 9;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int IMG_W_DEF = 150;
  localparam int IMG_H_DEF = 152;
  localparam int X0_DEF    = 245;
  localparam int Y0_DEF    = 164;

  typedef enum logic {
    S_WAIT_SOF = 1'b0,
    S_SCAN     = 1'b1
  } state_t;

endpackage

// File: rtl/pos_shadow.sv
// pos_shadow: one-entry holding register for image placement requests.
// A request is clamped on entry and copied into the committed placement
// only at a frame boundary, so the placement never changes mid-frame.
//
// Handshake: POS_READY is high while the shadow is empty. A request
// transfers on a cycle where POS_VALID and POS_READY are both high; the
// offerer must hold POS_X/POS_Y stable while POS_VALID is high and
// POS_READY is low. POS_READY does not depend on POS_VALID.
//
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   FRAME_START         commit strobe (one CLK)
//   POS_VALID/X/Y       placement offer
//   POS_READY           shadow empty
//   POS_DONE            one-CLK pulse after a commit
//   CUR_X / CUR_Y       committed placement
module pos_shadow
  import img_pkg::*;
#(
  parameter int X_RST = X0_DEF,
  parameter int Y_RST = Y0_DEF,
  parameter int X_MAX = H_ACTIVE - IMG_W_DEF,
  parameter int Y_MAX = V_ACTIVE - IMG_H_DEF
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           FRAME_START,
  input  logic           POS_VALID,
  input  logic [H_W-1:0] POS_X,
  input  logic [V_W-1:0] POS_Y,
  output logic           POS_READY,
  output logic           POS_DONE,
  output logic [H_W-1:0] CUR_X,
  output logic [V_W-1:0] CUR_Y
);

  localparam logic [H_W-1:0] X_LIM = H_W'(X_MAX);
  localparam logic [V_W-1:0] Y_LIM = V_W'(Y_MAX);

  logic           shadow_full;
  logic [H_W-1:0] shadow_x;
  logic [V_W-1:0] shadow_y;

  assign POS_READY = ~shadow_full;

  // Commit and accept are mutually exclusive: a commit needs a full
  // shadow, an accept needs an empty one. An offer arriving with
  // FRAME_START on an empty shadow is therefore held for the next frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_full <= 1'b0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      CUR_X       <= H_W'(X_RST);
      CUR_Y       <= V_W'(Y_RST);
      POS_DONE    <= 1'b0;
    end else begin
      POS_DONE <= FRAME_START & shadow_full;
      if (FRAME_START && shadow_full) begin
        CUR_X       <= shadow_x;
        CUR_Y       <= shadow_y;
        shadow_full <= 1'b0;
      end else if (POS_VALID && !shadow_full) begin
        shadow_x    <= (POS_X > X_LIM) ? X_LIM : POS_X;
        shadow_y    <= (POS_Y > Y_LIM) ? Y_LIM : POS_Y;
        shadow_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_fetch_ctrl.sv
// image_fetch_ctrl: frame-synchronous read scheduler for the image ROM.
// Qualifies the VGA scan position with the pixel tick, flags pixels that
// fall inside the placed image and walks the column-major ROM address
// (addr = col*IMG_H + row) incrementally without a multiplier.
//
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   PIX_EN              pixel tick; scan logic advances only when high
//   FRAME_START         one-CLK start-of-frame pulse
//   ADDRH / ADDRV       current scan column / row
//   POS_VALID/X/Y       placement offer (see pos_shadow)
//   POS_READY, POS_DONE placement handshake and commit pulse
//   ROM_ADDR            ROM read address (registered)
//   FETCH_VALID         one-CLK pulse per scanned pixel
//   IN_WINDOW           pixel lies inside the image
//   CUR_X / CUR_Y       committed placement
//   DBG_STATE           scheduler state
module image_fetch_ctrl
  import img_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int PIX_NUM = IMG_W_DEF * IMG_H_DEF,
  parameter int X0      = X0_DEF,
  parameter int Y0      = Y0_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              PIX_EN,
  input  logic              FRAME_START,
  input  logic [H_W-1:0]    ADDRH,
  input  logic [V_W-1:0]    ADDRV,
  input  logic              POS_VALID,
  input  logic [H_W-1:0]    POS_X,
  input  logic [V_W-1:0]    POS_Y,
  output logic              POS_READY,
  output logic              POS_DONE,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              FETCH_VALID,
  output logic              IN_WINDOW,
  output logic [H_W-1:0]    CUR_X,
  output logic [V_W-1:0]    CUR_Y,
  output state_t            DBG_STATE
);

  localparam int HX = H_W + 1;
  localparam int VX = V_W + 1;

  state_t         state;
  logic [HX-1:0]  x_end;
  logic [VX-1:0]  y_end;
  logic           in_x;
  logic           in_y;
  logic           in_win;
  logic           at_col0;
  logic [V_W-1:0] row_off;

  pos_shadow #(
    .X_RST (X0),
    .Y_RST (Y0),
    .X_MAX (H_ACTIVE - IMG_W),
    .Y_MAX (V_ACTIVE - IMG_H)
  ) u_pos_shadow (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .FRAME_START (FRAME_START),
    .POS_VALID   (POS_VALID),
    .POS_X       (POS_X),
    .POS_Y       (POS_Y),
    .POS_READY   (POS_READY),
    .POS_DONE    (POS_DONE),
    .CUR_X       (CUR_X),
    .CUR_Y       (CUR_Y)
  );

  // Window bounds are exclusive upper limits; one extra bit keeps the sum
  // from wrapping for any placement.
  assign x_end   = {1'b0, CUR_X} + HX'(IMG_W);
  assign y_end   = {1'b0, CUR_Y} + VX'(IMG_H);
  assign in_x    = (ADDRH >= CUR_X) && ({1'b0, ADDRH} < x_end);
  assign in_y    = (ADDRV >= CUR_Y) && ({1'b0, ADDRV} < y_end);
  assign in_win  = in_x & in_y;
  assign at_col0 = (ADDRH == CUR_X);
  assign row_off = ADDRV - CUR_Y;

  assign DBG_STATE = state;

  // The left edge of each image row seeds the address with the row offset;
  // every following in-window pixel is one column further, i.e. +IMG_H.
  // Out-of-window pixels leave the address untouched.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_WAIT_SOF;
      ROM_ADDR    <= '0;
      IN_WINDOW   <= 1'b0;
      FETCH_VALID <= 1'b0;
    end else begin
      FETCH_VALID <= 1'b0;
      case (state)
        S_WAIT_SOF: begin
          if (FRAME_START) state <= S_SCAN;
        end
        S_SCAN: begin
          if (PIX_EN) begin
            FETCH_VALID <= 1'b1;
            IN_WINDOW   <= in_win;
            if (in_win) begin
              if (at_col0) ROM_ADDR <= ADDR_W'(row_off);
              else         ROM_ADDR <= ROM_ADDR + ADDR_W'(IMG_H);
            end
          end
        end
        default: state <= S_WAIT_SOF;
      endcase
    end
  end

  a_addr_range: assert property (@(posedge CLK) disable iff (!RESET_N)
    ROM_ADDR < ADDR_W'(PIX_NUM));

endmodule

// File: tb/tb_image_fetch_ctrl.sv
module tb_image_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PIX_EN = 1'b0;
  logic        FRAME_START = 1'b0;
  logic [9:0]  ADDRH = '0;
  logic [8:0]  ADDRV = '0;
  logic        POS_VALID = 1'b0;
  logic [9:0]  POS_X = '0;
  logic [8:0]  POS_Y = '0;
  logic        POS_READY;
  logic        POS_DONE;
  logic [14:0] ROM_ADDR;
  logic        FETCH_VALID;
  logic        IN_WINDOW;
  logic [9:0]  CUR_X;
  logic [8:0]  CUR_Y;
  img_pkg::state_t dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  image_fetch_ctrl dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PIX_EN      (PIX_EN),
    .FRAME_START (FRAME_START),
    .ADDRH       (ADDRH),
    .ADDRV       (ADDRV),
    .POS_VALID   (POS_VALID),
    .POS_X       (POS_X),
    .POS_Y       (POS_Y),
    .POS_READY   (POS_READY),
    .POS_DONE    (POS_DONE),
    .ROM_ADDR    (ROM_ADDR),
    .FETCH_VALID (FETCH_VALID),
    .IN_WINDOW   (IN_WINDOW),
    .CUR_X       (CUR_X),
    .CUR_Y       (CUR_Y),
    .DBG_STATE   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Placement, shadow and scan state in plain integers; the fetch result
  // is the closed-form column-major address of the pixel.
  logic [15:0] exp_q[$];
  bit  m_scan  = 0;
  int  m_cx    = 245;
  int  m_cy    = 164;
  bit  m_full  = 0;
  int  m_sx    = 0;
  int  m_sy    = 0;
  int  e_addr  = 0;
  bit  e_in    = 0;
  bit  e_fv    = 0;
  bit  e_done  = 0;
  int  dx, dy;

  initial begin
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        m_scan = 0; m_cx = 245; m_cy = 164; m_full = 0;
        e_addr = 0; e_in = 0; e_fv = 0; e_done = 0;
        exp_q.delete();
      end else begin
        e_fv   = m_scan && PIX_EN;
        e_done = FRAME_START && m_full;
        if (e_fv) begin
          dx   = int'(ADDRH) - m_cx;
          dy   = int'(ADDRV) - m_cy;
          e_in = (dx >= 0) && (dx < 150) && (dy >= 0) && (dy < 152);
          if (e_in) e_addr = dx * 152 + dy;
          exp_q.push_back({e_in, 15'(e_addr)});
        end
        if (FRAME_START && m_full) begin
          m_cx = m_sx; m_cy = m_sy; m_full = 0;
        end else if (POS_VALID && !m_full) begin
          m_sx   = (int'(POS_X) > 640 - 150) ? 640 - 150 : int'(POS_X);
          m_sy   = (int'(POS_Y) > 480 - 152) ? 480 - 152 : int'(POS_Y);
          m_full = 1;
        end
        if (FRAME_START) m_scan = 1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [15:0] got;
  logic [15:0] want;

  initial begin
    forever begin
      @(negedge CLK);
      check("fetch_valid", FETCH_VALID, e_fv);
      check("rom_addr", ROM_ADDR, e_addr);
      check("in_window", IN_WINDOW, e_in);
      check("pos_ready", POS_READY, !m_full);
      check("pos_done", POS_DONE, e_done);
      check("cur_x", CUR_X, m_cx);
      check("cur_y", CUR_Y, m_cy);
      check("state_scan", dbg_state == img_pkg::S_SCAN, m_scan);
      if (FETCH_VALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", 1, 0);
        end else begin
          want = exp_q.pop_front();
          got  = {IN_WINDOW, ROM_ADDR};
          check("fetch_word", got, want);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pix(input int x, input int y);
    @(posedge CLK); #1;
    ADDRH  = 10'(x);
    ADDRV  = 9'(y);
    PIX_EN = 1'b1;
    @(posedge CLK); #1;
    PIX_EN = 1'b0;
  endtask

  task automatic pix_chk(input int x, input int y, input int fv, input int inw, input int addr);
    pix(x, y);
    check($sformatf("fv(%0d,%0d)", x, y), FETCH_VALID, fv);
    check($sformatf("in(%0d,%0d)", x, y), IN_WINDOW, inw);
    check($sformatf("addr(%0d,%0d)", x, y), ROM_ADDR, addr);
  endtask

  task automatic scan_row(input int y, input int lo, input int hi);
    for (int x = lo; x <= hi; x++) pix(x, y);
  endtask

  task automatic frame_start();
    @(posedge CLK); #1;
    FRAME_START = 1'b1;
    @(posedge CLK); #1;
    FRAME_START = 1'b0;
  endtask

  task automatic offer(input int x, input int y, input bit with_fs);
    @(posedge CLK); #1;
    POS_VALID   = 1'b1;
    POS_X       = 10'(x);
    POS_Y       = 9'(y);
    FRAME_START = with_fs;
    @(posedge CLK); #1;
    POS_VALID   = 1'b0;
    FRAME_START = 1'b0;
  endtask

  task automatic check_cur(input string tag, input int x, input int y);
    check({tag, "_cur_x"}, CUR_X, x);
    check({tag, "_cur_y"}, CUR_Y, y);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rom_addr", ROM_ADDR, 0);
    check("rst_in_window", IN_WINDOW, 0);
    check("rst_fetch_valid", FETCH_VALID, 0);
    check("rst_pos_ready", POS_READY, 1);
    check("rst_pos_done", POS_DONE, 0);
    check_cur("rst", 245, 164);
    RESET_N = 1'b1;

    // No fetches before the first frame start.
    pix_chk(300, 200, 0, 0, 0);

    // Default placement, two frames.
    frame_start();
    pix_chk(243, 164, 1, 0, 0);
    pix_chk(244, 164, 1, 0, 0);
    pix_chk(245, 164, 1, 1, 0);
    pix_chk(246, 164, 1, 1, 152);
    scan_row(164, 247, 393);
    pix_chk(394, 164, 1, 1, 22648);
    pix_chk(395, 164, 1, 0, 22648);
    scan_row(315, 244, 393);
    pix_chk(394, 315, 1, 1, 22799);
    pix_chk(395, 315, 1, 0, 22799);
    pix_chk(245, 316, 1, 0, 22799);
    pix_chk(245, 163, 1, 0, 22799);
    frame_start();
    pix_chk(245, 164, 1, 1, 0);
    pix_chk(246, 164, 1, 1, 152);

    // Mid-frame offer: committed only at the next frame start.
    offer(10, 20, 0);
    check("offer_ready", POS_READY, 0);
    check_cur("offer_hold", 245, 164);
    pix_chk(247, 164, 1, 1, 304);
    frame_start();
    check("commit_done", POS_DONE, 1);
    check_cur("commit", 10, 20);
    @(posedge CLK); #1;
    check("commit_done_low", POS_DONE, 0);
    check("commit_ready", POS_READY, 1);
    pix_chk(9, 20, 1, 0, 304);
    pix_chk(10, 20, 1, 1, 0);
    pix_chk(11, 20, 1, 1, 152);
    scan_row(20, 12, 158);
    pix_chk(159, 20, 1, 1, 22648);
    pix_chk(160, 20, 1, 0, 22648);

    // Out-of-range offer is clamped.
    offer(600, 400, 0);
    frame_start();
    check_cur("clamp", 490, 328);
    pix_chk(489, 328, 1, 0, 22648);
    pix_chk(490, 328, 1, 1, 0);
    pix_chk(491, 328, 1, 1, 152);
    pix_chk(490, 479, 1, 1, 151);

    // Offer together with frame start on an empty shadow.
    offer(100, 50, 1);
    check("same_cycle_ready", POS_READY, 0);
    check("same_cycle_done", POS_DONE, 0);
    check_cur("same_cycle", 490, 328);
    pix_chk(490, 328, 1, 1, 0);
    frame_start();
    check("same_cycle_commit_done", POS_DONE, 1);
    check_cur("same_cycle_commit", 100, 50);

    // Reset in mid-image with a pending shadow.
    offer(30, 30, 0);
    scan_row(60, 98, 119);
    pix_chk(120, 60, 1, 1, 3050);
    #1 RESET_N = 1'b0;
    #1;
    check("mid_rst_rom_addr", ROM_ADDR, 0);
    check("mid_rst_in_window", IN_WINDOW, 0);
    check("mid_rst_fetch_valid", FETCH_VALID, 0);
    check("mid_rst_pos_ready", POS_READY, 1);
    check_cur("mid_rst", 245, 164);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    pix_chk(250, 170, 0, 0, 0);
    frame_start();
    check("post_rst_done", POS_DONE, 0);
    check_cur("post_rst", 245, 164);

    // Pixel tick held low inside the window.
    scan_row(164, 243, 249);
    pix_chk(250, 164, 1, 1, 760);
    ADDRH = 10'd500;
    ADDRV = 9'd400;
    repeat (10) begin
      @(posedge CLK); #1;
      check("hold_fv", FETCH_VALID, 0);
      check("hold_addr", ROM_ADDR, 760);
    end
    pix_chk(251, 164, 1, 1, 912);

    repeat (3) @(posedge CLK);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
